uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with optional parity and break detection.
//
// Ports:
//   clk           - single clock, all logic on the rising edge
//   rst           - asynchronous, active-low reset
//   rx            - serial line, asynchronous to clk, idles high
//   rx_data       - last received data word, held until the next valid frame
//   rx_data_valid - one-cycle pulse marking a completed (non-break) frame
//   parity_error  - qualifies rx_data_valid: received parity did not match
//   frame_error   - qualifies rx_data_valid: a stop bit was sampled low
//   break_detect  - one-cycle pulse: every sample from start to last stop was low
//   busy          - high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter string       PARITY_BIT   = "none",
    parameter int unsigned STOP_BITS    = 2,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_detect,
    output logic                 busy
);

    localparam bit          ParityEn  = (PARITY_BIT != "none");
    localparam bit          ParityOdd = (PARITY_BIT == "odd");
    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned MaxBits   = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned BitW      = $clog2(MaxBits + 1);

    localparam logic [CntW-1:0] SampleAt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } state_e;

    state_e                 state_q;
    logic [1:0]             sync_q;
    logic                   prev_q;      // previous synchronized level, for edge detection
    logic [CntW-1:0]        cnt_q;
    logic [BitW-1:0]        bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;       // running XOR of data bits
    logic                   low_q;       // every sample so far in this frame was low
    logic                   perr_pend_q;
    logic                   ferr_pend_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   valid_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   brk_q;

    logic rx_s;
    logic mid;

    assign rx_s = sync_q[1];
    assign mid  = (cnt_q == SampleAt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            low_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            valid_q <= 1'b0;
            brk_q   <= 1'b0;

            // Bit-period counter free-runs while a frame is in progress.
            if (state_q == StIdle || state_q == StBreakWait) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (prev_q && !rx_s) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (mid) begin
                        if (rx_s) begin
                            state_q <= StIdle;  // glitch, not a real start bit
                        end else begin
                            state_q     <= StData;
                            bit_q       <= '0;
                            par_q       <= 1'b0;
                            low_q       <= 1'b1;
                            perr_pend_q <= 1'b0;
                            ferr_pend_q <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (mid) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        par_q   <= par_q ^ rx_s;
                        low_q   <= low_q & ~rx_s;
                        if (bit_q == LastData) begin
                            bit_q   <= '0;
                            state_q <= ParityEn ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end
                end
                StParity: begin
                    if (mid) begin
                        perr_pend_q <= ((par_q ^ rx_s) != ParityOdd);
                        low_q       <= low_q & ~rx_s;
                        state_q     <= StStop;
                    end
                end
                StStop: begin
                    if (mid) begin
                        if (bit_q != LastStop) begin
                            ferr_pend_q <= ferr_pend_q | ~rx_s;
                            low_q       <= low_q & ~rx_s;
                            bit_q       <= bit_q + BitW'(1);
                        end else begin
                            bit_q <= '0;
                            if (low_q && !rx_s) begin
                                // Break: outputs keep the previous frame's values.
                                brk_q   <= 1'b1;
                                state_q <= StBreakWait;
                            end else begin
                                valid_q   <= 1'b1;
                                rx_data_q <= shift_q;
                                perr_q    <= perr_pend_q;
                                ferr_q    <= ferr_pend_q | ~rx_s;
                                state_q   <= StIdle;
                            end
                        end
                    end
                end
                StBreakWait: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign parity_error  = perr_q;
    assign frame_error   = ferr_q;
    assign break_detect  = brk_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: one default instance (no parity, 2 stop bits) and one
// even-parity instance, each on its own serial line.
module tb_uart_rx;

    localparam int CLK_PERIOD = 10;
    localparam int BIT        = 16;
    localparam int LAT_A      = 3 + (8 + 0 + 2) * BIT + BIT / 2;
    localparam int LAT_B      = 3 + (8 + 1 + 2) * BIT + BIT / 2;

    logic       clk;
    logic       rst;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       va, vb, pea, peb, fea, feb, ba, bb, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int nva = 0, nvb = 0, nba = 0, nbb = 0, excl_viol = 0;
    int tva = 0, tvb = 0;
    logic [7:0] dva = '0, dvb = '0;
    logic pva = 1'b0, pvb = 1'b0, fva = 1'b0, fvb = 1'b0;

    uart_rx dut_a (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx_a),
        .rx_data       (data_a),
        .rx_data_valid (va),
        .parity_error  (pea),
        .frame_error   (fea),
        .break_detect  (ba),
        .busy          (busy_a)
    );

    uart_rx #(.PARITY_BIT("even")) dut_b (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx_b),
        .rx_data       (data_b),
        .rx_data_valid (vb),
        .parity_error  (peb),
        .frame_error   (feb),
        .break_detect  (bb),
        .busy          (busy_b)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (va) begin
            nva = nva + 1; tva = cyc; dva = data_a; pva = pea; fva = fea;
        end
        if (vb) begin
            nvb = nvb + 1; tvb = cyc; dvb = data_b; pvb = peb; fvb = feb;
        end
        if (ba) nba = nba + 1;
        if (bb) nbb = nbb + 1;
        if ((va && ba) || (vb && bb)) excl_viol = excl_viol + 1;
    end

    initial begin
        #(100000 * CLK_PERIOD);
        $display("FAIL watchdog: simulation did not complete within the cycle budget");
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        bit         sel;
        logic [7:0] data;
        bit         par_bit;
        bit         stop2;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_bit,
                              input bit stop2, output int t0);
        logic [11:0] seq;
        int          n;
        seq      = '1;
        seq[0]   = 1'b0;
        seq[8:1] = data;
        if (sel) begin
            seq[9]  = par_bit;
            seq[10] = 1'b1;
            seq[11] = stop2;
            n       = 12;
        end else begin
            seq[9]  = 1'b1;
            seq[10] = stop2;
            n       = 11;
        end
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            set_rx(sel, seq[i]);
            repeat (BIT) @(posedge clk);
            #1;
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic run_frame(input string name, input bit sel, input logic [7:0] data,
                             input bit par_bit, input bit stop2, input logic [7:0] exp_data,
                             input bit exp_perr, input bit exp_ferr);
        int t0, nv0, nb0;
        nv0 = sel ? nvb : nva;
        nb0 = sel ? nbb : nba;
        send_frame(sel, data, par_bit, stop2, t0);
        repeat (2) @(posedge clk);
        #1;
        check({name, " valid count"}, sel ? nvb - nv0 : nva - nv0, 1);
        check({name, " break count"}, sel ? nbb - nb0 : nba - nb0, 0);
        check({name, " latency"}, (sel ? tvb : tva) - t0, sel ? LAT_B : LAT_A);
        check({name, " rx_data"}, sel ? dvb : dva, exp_data);
        check({name, " parity_error"}, sel ? pvb : pva, exp_perr);
        check({name, " frame_error"}, sel ? fvb : fva, exp_ferr);
        check({name, " rx_data held"}, sel ? data_b : data_a, exp_data);
        check({name, " busy after"}, sel ? busy_b : busy_a, 0);
    endtask

    initial begin
        int nv0, nb0, t0;

        vecs[0] = '{"a_00",        1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{"a_ff",        1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{"a_a3_stop2",  1'b0, 8'hA3, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1};
        vecs[3] = '{"a_3c_clean",  1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{"a_00_stop2",  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{"b_55_p0",     1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[6] = '{"b_55_p1",     1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[7] = '{"b_80_p1",     1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{"b_00_stop2",  1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        rx_a = 1'b1;
        rx_b = 1'b1;
        rst  = 1'b0;
        #(2 * CLK_PERIOD + 3);
        check("reset rx_data", data_a, 8'h00);
        check("reset valid", va, 0);
        check("reset break", ba, 0);
        check("reset busy", busy_a, 0);
        check("reset errors", {pea, fea, peb, feb}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post-reset busy", {busy_a, busy_b}, 2'b00);

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].sel, vecs[i].data, vecs[i].par_bit, vecs[i].stop2,
                      vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        for (int b = 0; b < 256; b++) begin
            run_frame("sweep", 1'b0, 8'(b), 1'b0, 1'b1, 8'(b), 1'b0, 1'b0);
        end

        // Short glitch: START must abort at its mid-bit sample.
        nv0 = nva;
        @(posedge clk); #1;
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch busy high", busy_a, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch busy low", busy_a, 0);
        check("glitch no valid", nva - nv0, 0);

        // Break: 20 bit periods low; outputs keep the 0xFF frame.
        nv0 = nva;
        nb0 = nba;
        @(posedge clk); #1;
        rx_a = 1'b0;
        repeat (20 * BIT) @(posedge clk);
        #1;
        check("break pulse count", nba - nb0, 1);
        check("break no valid", nva - nv0, 0);
        check("break busy during low", busy_a, 1);
        check("break rx_data kept", data_a, 8'hFF);
        check("break flags kept", {pea, fea}, 2'b00);
        rx_a = 1'b1;
        @(negedge clk);
        check("break busy at release", busy_a, 1);
        repeat (5) @(posedge clk);
        #1;
        check("break busy after high", busy_a, 0);
        check("break single pulse", nba - nb0, 1);
        run_frame("after_break_7e", 1'b0, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);

        // Reset asserted during DATA of 0xFF.
        nv0 = nva;
        nb0 = nba;
        @(posedge clk); #1;
        t0 = cyc;
        rx_a = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("mid-frame busy", busy_a, 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (9 * BIT) @(posedge clk);
        #1;
        check("reset-drop no valid", nva - nv0, 0);
        check("reset-drop no break", nba - nb0, 0);
        check("reset-drop rx_data", data_a, 8'h00);
        check("reset-drop busy", busy_a, 0);
        run_frame("after_reset_12", 1'b0, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);

        check("valid/break exclusive", excl_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
